// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//
// Sequences 16- and 32-bit loads and stores from the pipeline memory stage
// onto a 16-bit synchronous data memory. A 32-bit access takes two word
// transfers, at addr and addr+1. The memory returns read data on Data in
// the cycle after the edge that sampled the read strobe.
//
// Optional feature, macro MEM_BOUNDS_CHECK_EN:
//   defined   - requests that touch a word above ADDR_LIMIT are rejected
//               with a one-cycle addr_fault pulse and never reach memory.
//   undefined - no range check; addr_fault is tied low.
//
// Parameters
//   ADDR_LIMIT   highest legal data-memory word address
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   req_valid    request present from the pipeline
//   req_write    1 = store, 0 = load
//   req_double   1 = 32-bit access (two words), 0 = 16-bit access
//   req_addr     word address
//   req_wdata    store data; a 16-bit access uses [15:0]
//   req_ready    request accepted this cycle; low = pipeline stall
//   memoryRead   memory read strobe
//   memorywrite  memory write strobe
//   Readaddress  memory word address
//   writedata    memory write word
//   Data         memory read word
//   rsp_valid    one-cycle completion pulse
//   rsp_data     load result; a 16-bit load is zero-extended
//   addr_fault   one-cycle pulse when a request is rejected as out of range
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request
// ACC0  | first word transfer at addr
// ACC1  | second word transfer at addr+1 (32-bit only); low load word lands
// CAPT  | last load word lands on Data; strobes low
// RESP  | rsp_valid pulse, then back to IDLE

module mem_access_ctrl #(
    parameter logic [15:0] ADDR_LIMIT = 16'h07FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic        req_double,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        memoryRead,
    output logic        memorywrite,
    output logic [15:0] Readaddress,
    output logic [15:0] writedata,
    input  logic [15:0] Data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        addr_fault
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        double_q;
    logic        req_fault;
    logic        accept;

`ifdef MEM_BOUNDS_CHECK_EN
    // 17-bit compare so a 32-bit access at 16'hFFFF counts as out of range
    // instead of wrapping to word 0.
    logic [16:0] addr_lo_ext;
    logic [16:0] addr_hi_ext;
    logic        fault_q;

    assign addr_lo_ext = {1'b0, req_addr};
    assign addr_hi_ext = addr_lo_ext + 17'd1;
    assign req_fault   = (addr_lo_ext > {1'b0, ADDR_LIMIT}) ||
                         (req_double && (addr_hi_ext > {1'b0, ADDR_LIMIT}));

    // A rejected request leaves the FSM in IDLE; only this pulse reports it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state == IDLE) && req_valid && req_fault;
        end
    end

    assign addr_fault = fault_q;
`else
    assign req_fault  = 1'b0;
    assign addr_fault = 1'b0;
`endif

    assign accept = (state == IDLE) && req_valid && !req_fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= 16'h0000;
            wdata_q  <= 32'h0000_0000;
            write_q  <= 1'b0;
            double_q <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            write_q  <= req_write;
            double_q <= req_double;
        end
    end

    // Data trails its read strobe by one cycle, so the low word of a 32-bit
    // load is on Data during ACC1 and the last word is on Data during CAPT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_data <= 32'h0000_0000;
        end else if (!write_q) begin
            if (state == ACC1) begin
                rsp_data[15:0] <= Data;
            end else if (state == CAPT) begin
                if (double_q) begin
                    rsp_data[31:16] <= Data;
                end else begin
                    rsp_data <= {16'h0000, Data};
                end
            end
        end
    end

    // Strobes decode from the state register alone, so a reset drops them
    // immediately.
    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        memoryRead  = 1'b0;
        memorywrite = 1'b0;
        Readaddress = 16'h0000;
        writedata   = 16'h0000;
        rsp_valid   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    state_next = ACC0;
                end
            end
            ACC0: begin
                memoryRead  = !write_q;
                memorywrite = write_q;
                Readaddress = addr_q;
                writedata   = wdata_q[15:0];
                state_next  = double_q ? ACC1 : CAPT;
            end
            ACC1: begin
                memoryRead  = !write_q;
                memorywrite = write_q;
                Readaddress = addr_q + 16'd1;
                writedata   = wdata_q[31:16];
                state_next  = CAPT;
            end
            CAPT: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 16'h07FF, the highest legal data-memory word address.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: the pipeline memory stage presents a request.
REQ-005 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_double, input, 1 bit: 1 = 32-bit access (two words), 0 = 16-bit access.
REQ-007 SHALL have port req_addr, input, 16 bits: word address.
REQ-008 SHALL have port req_wdata, input, 32 bits: store data; a single access uses [15:0].
REQ-009 SHALL have port req_ready, output, 1 bit: the controller accepts a request this cycle; when low it is the pipeline stall.
REQ-010 SHALL have port memoryRead, output, 1 bit: read strobe to the data memory.
REQ-011 SHALL have port memorywrite, output, 1 bit: write strobe to the data memory.
REQ-012 SHALL have port Readaddress, output, 16 bits: data memory address.
REQ-013 SHALL have port writedata, output, 16 bits: data memory write word.
REQ-014 SHALL have port Data, input, 16 bits: data memory read word, valid the cycle after a read strobe edge.
REQ-015 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port rsp_data, output, 32 bits: load result; a single access is zero-extended.
REQ-017 SHALL have port addr_fault, output, 1 bit: one-cycle pulse when a request is rejected as out of range.

Function
REQ-018 SHALL implement states IDLE, ACC0, ACC1, CAPT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL accept a request at a rising edge in IDLE with req_valid=1, register addr/write/double/wdata, and go to ACC0.
REQ-020 In ACC0 SHALL drive Readaddress=addr, the strobe matching req_write, and writedata=wdata[15:0]; next state ACC1 if double, else CAPT.
REQ-021 In ACC1 SHALL drive Readaddress=addr+1 (16-bit wrap), the same strobe, and writedata=wdata[31:16]; on a load it SHALL capture Data into rsp_data[15:0]; next state CAPT.
REQ-022 In CAPT on a load SHALL capture Data into rsp_data[31:16] if double, else into rsp_data[15:0] with [31:16]=0; strobes low; next state RESP.
REQ-023 In RESP SHALL assert rsp_valid for exactly one cycle, hold rsp_data, and return to IDLE; rsp_data SHALL be held until the next load captures.
REQ-024 Latency SHALL be request edge to rsp_valid = 3 cycles single, 4 cycles double; stores also pulse rsp_valid with rsp_data unchanged.
REQ-025 Outside ACC0/ACC1, memoryRead and memorywrite SHALL be 0, and both SHALL never be high together.
REQ-026 req_valid in non-IDLE states SHALL be ignored; the pipeline SHALL hold the request while req_ready=0.

Reset
REQ-027 On reset low, SHALL go to IDLE immediately, including mid-access, and abandon any transfer with no further strobes and no rsp_valid.
REQ-028 Reset values SHALL be: req_ready=1 (0 while reset is low is permitted), strobes=0, Readaddress=0, writedata=0, rsp_valid=0, rsp_data=0, addr_fault=0.

Configuration
REQ-029 With MEM_BOUNDS_CHECK_EN defined, a request with addr>ADDR_LIMIT, or a double request with addr+1>ADDR_LIMIT, SHALL issue no strobe, pulse addr_fault one cycle after acceptance, and return to IDLE with no rsp_valid.
REQ-030 Without MEM_BOUNDS_CHECK_EN, SHALL perform no range check, SHALL tie addr_fault to 0, and SHALL pass every address to memory.

Verification
REQ-031 Single store addr=16'h0010, wdata=32'h0000_BEEF -> ACC0 memorywrite=1, Readaddress=0010, writedata=BEEF; rsp_valid at cycle +3.
REQ-032 Double load at 16'h0020 with mem[0020]=1234 and mem[0021]=5678 -> two read strobes, rsp_data=32'h5678_1234, rsp_valid at cycle +4.
REQ-033 Back-to-back requests held on req_valid -> second is accepted only after the first RESP; req_ready is low for 3 or 4 cycles.
REQ-034 MEM_BOUNDS_CHECK_EN, double load at 16'h07FF -> no strobe, addr_fault pulse, no rsp_valid; without the macro -> reads at 07FF and 0800.
REQ-035 Reset asserted during ACC1 of a double store -> strobes drop asynchronously, state is IDLE, no rsp_valid, and word addr+1 is not written.
